// File: rtl/cpu_defs.sv
// cpu_defs: shared types for the memory-stage data bridge.
package cpu_defs;

  // Bridge handshake state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } bridge_state_t;

  // Access size encoding, shared by the CPU port and the bus.
  typedef logic [1:0] size_t;

  localparam size_t SIZE_BYTE = 2'd0;
  localparam size_t SIZE_HALF = 2'd1;
  localparam size_t SIZE_WORD = 2'd2;

endpackage : cpu_defs

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns the single-cycle memory-stage data port into a
// split request/response bus (addr_ok/data_ok), stalling the pipeline
// until the single outstanding access completes.
module dmem_bridge
  import cpu_defs::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  // CPU memory-stage side
  input  logic              cpu_en,
  input  logic [STRB_W-1:0] cpu_wen,
  input  size_t             cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_longstall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  // Bus side
  output logic              data_req,
  output logic              data_wr,
  output size_t             data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [STRB_W-1:0] data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  bridge_state_t     state_q, state_d;
  logic              latch_c;
  logic              capture_c;

  logic              req_q;
  logic              wr_q;
  size_t             size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic [DATA_W-1:0] rdata_q;

  // State register; reset aborts any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, stall, and latch/capture strobes.
  // Stall depends on state and cpu_en only, never on the bus response.
  always_comb begin
    state_d   = state_q;
    cpu_stall = 1'b0;
    latch_c   = 1'b0;
    capture_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cpu_stall = cpu_en;
        if (cpu_en) begin
          latch_c = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        cpu_stall = 1'b1;
        if (data_addr_ok) begin
          if (data_ok) begin
            capture_c = ~wr_q;
            state_d   = ST_DONE;
          end else begin
            state_d   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cpu_stall = 1'b1;
        if (data_ok) begin
          capture_c = ~wr_q;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        // Hold here so a frozen pipeline cannot re-issue the same access.
        if (!cpu_longstall) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered bus request and latched access attributes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      req_q <= (state_d == ST_REQ);
      if (latch_c) begin
        wr_q    <= |cpu_wen;
        size_q  <= cpu_size;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        strb_q  <= cpu_wen;
      end
    end
  end

  // Load data register; stores leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (capture_c) begin
      rdata_q <= data_rdata;
    end
  end

  assign data_req   = req_q;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign data_wstrb = strb_q;
  assign cpu_rdata  = rdata_q;

endmodule : dmem_bridge

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed + randomized checks of dmem_bridge against a
// transaction-level model (expected stall/request cycle counts per access
// and the last completed load value).
module tb_dmem_bridge;

  logic        clk;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_longstall;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_ok;
  logic [31:0] data_rdata;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int exp_req = 0;
  logic [31:0] exp_rdata = '0;

  dmem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_en       (cpu_en),
    .cpu_wen      (cpu_wen),
    .cpu_size     (cpu_size),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_longstall(cpu_longstall),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_wstrb   (data_wstrb),
    .data_addr_ok (data_addr_ok),
    .data_ok      (data_ok),
    .data_rdata   (data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle the bus sees a request.
  always @(posedge clk) begin
    if (data_req) req_cnt <= req_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One access: a = REQ cycles without addr_ok, d = WAIT cycles (0: data_ok with addr_ok),
  // ls = extra DONE cycles held by longstall, spur = inject ignored handshakes.
  task automatic access(input logic [31:0] addr, input logic [3:0] wen,
                        input logic [31:0] wdata, input logic [1:0] size,
                        input logic [31:0] rdata, input int a, input int d,
                        input int ls, input bit spur);
    bit is_load;
    is_load = (wen == 4'b0000);
    // IDLE cycle with the request presented
    @(negedge clk);
    cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata; cpu_size = size;
    cpu_longstall = 1'b0;
    data_addr_ok = spur ? 1'($urandom) : 1'b0;
    data_ok = spur ? 1'($urandom) : 1'b0;
    data_rdata = $urandom;
    #1;
    check("idle_stall", 32'(cpu_stall), 32'd1);
    check("idle_req", 32'(data_req), 32'd0);
    exp_req += a + 1;
    // REQ cycles; CPU inputs scrambled to prove they are not resampled
    for (int k = 0; k <= a; k++) begin
      @(negedge clk);
      cpu_en = 1'($urandom); cpu_addr = $urandom; cpu_wen = 4'($urandom);
      cpu_wdata = $urandom; cpu_size = 2'($urandom);
      data_addr_ok = (k == a);
      data_ok = (k == a) ? (d == 0) : (spur && ($urandom % 2 == 1));
      data_rdata = (k == a && d == 0) ? rdata : $urandom;
      #1;
      check("req_req", 32'(data_req), 32'd1);
      check("req_stall", 32'(cpu_stall), 32'd1);
      check("req_addr", data_addr, addr);
      check("req_wdata", data_wdata, wdata);
      check("req_wstrb", 32'(data_wstrb), 32'(wen));
      check("req_wr", 32'(data_wr), 32'(!is_load));
      check("req_size", 32'(data_size), 32'(size));
      check("req_rdata", cpu_rdata, exp_rdata);
    end
    // WAIT cycles
    for (int j = 1; j <= d; j++) begin
      @(negedge clk);
      cpu_en = 1'($urandom);
      data_addr_ok = spur ? 1'($urandom) : 1'b0;
      data_ok = (j == d);
      data_rdata = (j == d) ? rdata : $urandom;
      #1;
      check("wait_req", 32'(data_req), 32'd0);
      check("wait_stall", 32'(cpu_stall), 32'd1);
    end
    if (is_load) exp_rdata = rdata;
    // DONE cycle(s)
    @(negedge clk);
    cpu_en = 1'b0;
    cpu_longstall = (ls > 0);
    data_addr_ok = spur ? 1'($urandom) : 1'b0;
    data_ok = spur ? 1'($urandom) : 1'b0;
    data_rdata = $urandom;
    #1;
    check("done_stall", 32'(cpu_stall), 32'd0);
    check("done_req", 32'(data_req), 32'd0);
    check("done_rdata", cpu_rdata, exp_rdata);
    for (int i = 1; i <= ls; i++) begin
      @(negedge clk);
      cpu_en = 1'($urandom);
      cpu_longstall = (i < ls);
      #1;
      check("hold_stall", 32'(cpu_stall), 32'd0);
      check("hold_req", 32'(data_req), 32'd0);
      check("hold_rdata", cpu_rdata, exp_rdata);
    end
  endtask

  // Quiet cycles with spurious bus handshakes that must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cpu_en = 1'b0;
      cpu_longstall = 1'($urandom);
      data_addr_ok = 1'($urandom);
      data_ok = 1'($urandom);
      data_rdata = $urandom;
      #1;
      check("idle_q_stall", 32'(cpu_stall), 32'd0);
      check("idle_q_req", 32'(data_req), 32'd0);
      check("idle_q_rdata", cpu_rdata, exp_rdata);
    end
  endtask

  initial begin
    bit ld;
    logic [3:0] wen;
    rst = 1'b0; cpu_en = 1'b0; cpu_wen = '0; cpu_size = '0; cpu_addr = '0;
    cpu_wdata = '0; cpu_longstall = 1'b0; data_addr_ok = 1'b0; data_ok = 1'b0;
    data_rdata = '0;
    #2 rst = 1'b1;
    #1;
    check("rst_req", 32'(data_req), 32'd0);
    check("rst_wr", 32'(data_wr), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_addr", data_addr, 32'd0);
    check("rst_wdata", data_wdata, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_wstrb", 32'(data_wstrb), 32'd0);
    check("rst_size", 32'(data_size), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Load, zero wait
    access(32'h8000_0010, 4'b0000, 32'h0, 2'd2, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
    idle(1);
    // Store with waits: addr_ok after 3 cycles, data_ok 2 later
    access(32'h8000_0020, 4'b0011, 32'h0000_1234, 2'd1, 32'h5555_AAAA, 3, 2, 0, 1'b0);
    idle(2);
    // Longstall hold across DONE
    access(32'h8000_0030, 4'b0000, 32'h0, 2'd2, 32'hCAFE_F00D, 1, 1, 4, 1'b0);
    // Spurious responses in IDLE and in REQ before addr_ok
    idle(3);
    access(32'h8000_0040, 4'b0000, 32'h0, 2'd0, 32'h0123_4567, 3, 1, 0, 1'b1);
    // Back-to-back loads
    access(32'h8000_0050, 4'b0000, 32'h0, 2'd2, 32'h1111_2222, 0, 0, 0, 1'b0);
    access(32'h8000_0054, 4'b0000, 32'h0, 2'd2, 32'h3333_4444, 0, 1, 0, 1'b0);

    // Reset in WAIT, then a late data_ok
    @(negedge clk);
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h8000_0060; cpu_size = 2'd2;
    data_addr_ok = 1'b0; data_ok = 1'b0;
    @(negedge clk);
    cpu_en = 1'b0; data_addr_ok = 1'b1; data_ok = 1'b0;
    @(negedge clk);
    data_addr_ok = 1'b0; data_ok = 1'b0;
    #1;
    check("wait_pre_rst_stall", 32'(cpu_stall), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_req", 32'(data_req), 32'd0);
    check("midrst_stall", 32'(cpu_stall), 32'd0);
    check("midrst_addr", data_addr, 32'd0);
    check("midrst_rdata", cpu_rdata, 32'd0);
    check("midrst_wstrb", 32'(data_wstrb), 32'd0);
    exp_req += 1;
    exp_rdata = '0;
    @(negedge clk);
    rst = 1'b0; data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
    #1;
    check("late_ok_stall", 32'(cpu_stall), 32'd0);
    @(negedge clk);
    data_ok = 1'b0;
    #1;
    check("late_ok_rdata", cpu_rdata, 32'd0);
    check("late_ok_req", 32'(data_req), 32'd0);

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      ld = 1'($urandom);
      wen = ld ? 4'b0000 : 4'($urandom_range(1, 15));
      access($urandom, wen, $urandom, 2'($urandom_range(0, 2)), $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), 1'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    @(negedge clk);
    check("req_cycle_total", 32'(req_cnt), 32'(exp_req));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dmem_bridge

// File: doc/dmem_bridge.md
# dmem_bridge

Converts the CPU's single-cycle memory-stage data port into a split request/response bus with `addr_ok`/`data_ok` handshakes. It sits between the memory-access stage's byte-select/store-data logic and the data SRAM/AXI-side bridge. It holds the pipeline via `cpu_stall` until the access completes. It issues each access exactly once, even while the pipeline is frozen by other stall sources.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `DATA_W/8` byte strobes

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `cpu_en`  in  1  valid load/store in the memory stage; already gated by exceptions
- `cpu_wen`  in  4  byte write enables; 0 = load
- `cpu_size`  in  2  0 byte, 1 half, 2 word
- `cpu_addr`  in  ADDR_W  byte address
- `cpu_wdata`  in  DATA_W  lane-aligned store data
- `cpu_longstall`  in  1  pipeline held by another source (divider, etc.)
- `cpu_rdata`  out  DATA_W  load data, held until next load completes
- `cpu_stall`  out  1  hold the memory stage and everything upstream
- `data_req`  out  1  bus request
- `data_wr`  out  1  1 = write
- `data_size`  out  2  copy of `cpu_size`
- `data_addr`  out  ADDR_W  latched address
- `data_wdata`  out  DATA_W  latched store data
- `data_wstrb`  out  4  latched `cpu_wen`
- `data_addr_ok`  in  1  request accepted
- `data_ok`  in  1  response valid, one cycle
- `data_rdata`  in  DATA_W  response data

## Operation
States are `IDLE`, `REQ`, `WAIT`, `DONE`.

- **IDLE:** if `cpu_en`, latch addr/wdata/wstrb/size, set `data_wr = |cpu_wen`, go to `REQ`. `cpu_stall = cpu_en`.
- **REQ:** `data_req = 1`; all `data_*` outputs stable.
  - `addr_ok & data_ok` → `DONE`.
  - `addr_ok` alone → `WAIT`.
  - Otherwise stay in `REQ`.
  - `cpu_stall = 1`.
- **WAIT:** `data_req = 0`. `data_ok` → `DONE`. `cpu_stall = 1`.
- **DONE:** `cpu_stall = 0`. Stay while `cpu_longstall`, else go to `IDLE`.
- **Read-data capture:** on the `data_ok` edge into `DONE`, `cpu_rdata <= data_rdata` if it is a load. Stores leave `cpu_rdata` unchanged.
- **Ignored inputs:**
  - `cpu_en` and the `cpu_*` inputs are sampled only in `IDLE`. Deassertion of `cpu_en` during `REQ`/`WAIT` does not cancel the access.
  - `data_ok` in `IDLE`, or in `REQ` without `addr_ok`, is ignored.
  - `data_addr_ok` outside `REQ` is ignored.
- **At most one outstanding transaction.** No pipelining of requests.
- **`cpu_stall` is combinational** from state and `cpu_en` only. There is no combinational path from `data_ok` to `cpu_stall`.

## Timing
- **Reset values:** state `IDLE`. `data_req`, `data_wr`, `cpu_stall` = 0. `data_addr`, `data_wdata`, `cpu_rdata` = 0. `data_wstrb`, `data_size` = 0.
- **Reset mid-transaction:** return to `IDLE` immediately and drop `data_req`. A late `data_ok` is ignored.
- **Minimum latency** (`addr_ok` and `data_ok` in the first `REQ` cycle): `cpu_stall` high for 2 cycles (`IDLE`, `REQ`), low in the `DONE` cycle.
- **Back-to-back accesses:** the next access starts from `IDLE` one cycle after `DONE`. This gives one stall cycle minimum per access. No access is reissued while `cpu_longstall` holds `DONE`.

## Structure
- **Shared package (`cpu_defs`):** state enum `bridge_state_t`, size encodings `SIZE_BYTE`/`SIZE_HALF`/`SIZE_WORD`.
- **Module:** single module, no sub-module. The `DONE`-hold and rdata register live inline.

## Test plan
- **Load, zero wait:** `cpu_en=1`, `cpu_wen=0`, addr `0x8000_0010`; bus gives `addr_ok` and `data_ok` in the first `REQ` cycle with rdata `0xDEADBEEF` → exactly one `data_req` cycle, `cpu_stall` high for 2 cycles, `cpu_rdata=0xDEADBEEF` in `DONE`.
- **Store with waits:** `wen=4'b0011`, wdata `0x0000_1234`; `addr_ok` after 3 cycles, `data_ok` 2 cycles later → addr/wdata/wstrb stable throughout `REQ`, `data_wr=1`, `cpu_rdata` unchanged, stall ends on the `DONE` cycle.
- **Longstall hold:** `cpu_longstall=1` for 4 cycles across `DONE` → single bus request, no re-issue, `cpu_rdata` held.
- **Spurious response:** `data_ok` pulses in `IDLE` and in `REQ` before `addr_ok` → ignored; `cpu_rdata` and state unaffected.
- **Reset mid-WAIT:** assert `rst` in `WAIT` → all outputs at reset values that cycle, `data_ok` the following cycle ignored.
- **Back-to-back:** two consecutive loads → second `data_req` begins exactly 2 cycles after the first `DONE`, data captured correctly for each.
